// File: rtl/reduceron_pkg.sv
// Shared types for the Reduceron run monitor: default bus widths, FSM states
// and the record layout a host-side decoder sees at default widths.
package reduceron_pkg;

    localparam int RES_W_DEF   = 18;
    localparam int STATE_W_DEF = 7;
    localparam int HEAP_W_DEF  = 15;
    localparam int CYC_W_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } run_state_e;

    typedef struct packed {
        logic [RES_W_DEF-1:0]   res;
        logic [STATE_W_DEF-1:0] st;
        logic [HEAP_W_DEF-1:0]  heap;
        logic [HEAP_W_DEF-1:0]  peak;
        logic [CYC_W_DEF-1:0]   cycles;
        logic                   timeout;
    } run_rec_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. inc_o is the value the
// counter would take on an enabled edge, so callers can capture it early.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] inc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign inc_o   = (&count_q) ? count_q : count_q + 1'b1;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = inc_o;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reduceron_run_monitor.sv
// Watches a Reduceron run from start to finish (or watchdog expiry) and offers
// a result record on a registered valid/ready port.
module reduceron_run_monitor
    import reduceron_pkg::*;
#(
    parameter int          RES_W   = RES_W_DEF,
    parameter int          STATE_W = STATE_W_DEF,
    parameter int          HEAP_W  = HEAP_W_DEF,
    parameter int          CYC_W   = CYC_W_DEF,
    parameter int unsigned TIMEOUT = 2**24
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [RES_W-1:0]   res,
    input  logic [STATE_W-1:0] st,
    input  logic [HEAP_W-1:0]  heap,
    input  logic               finish,
    output logic               busy,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [RES_W-1:0]   rec_res,
    output logic [STATE_W-1:0] rec_st,
    output logic [HEAP_W-1:0]  rec_heap,
    output logic [HEAP_W-1:0]  rec_peak,
    output logic [CYC_W-1:0]   rec_cycles,
    output logic               rec_timeout,
    output run_state_e         dbg_state
);

    // A limit the saturating counter can never reach is treated as disabled.
    localparam bit WD_EN = (TIMEOUT != 0) && ((64'(TIMEOUT) >> CYC_W) == 64'd0);
    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

    run_state_e        state_q;
    logic [HEAP_W-1:0] peak_q;
    logic [HEAP_W-1:0] peak_d;
    logic [CYC_W-1:0]  cnt_q;
    logic [CYC_W-1:0]  cnt_inc;
    logic              cnt_clr;
    logic              cnt_en;
    logic              wd_hit;

    assign cnt_clr = (state_q == ST_IDLE) && start;
    assign cnt_en  = (state_q == ST_RUN);
    assign peak_d  = (heap > peak_q) ? heap : peak_q;
    assign wd_hit  = WD_EN && (cnt_inc == TIMEOUT_C);

    sat_counter #(.W(CYC_W)) u_cycle_cnt (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .count_o   (cnt_q),
        .inc_o     (cnt_inc)
    );

    // Valid/ready: a record is offered with rec_valid=1 and every rec_* field
    // stable until an edge sees rec_valid & rec_ready; that edge retires it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            peak_q      <= '0;
            busy        <= 1'b0;
            rec_valid   <= 1'b0;
            rec_res     <= '0;
            rec_st      <= '0;
            rec_heap    <= '0;
            rec_peak    <= '0;
            rec_cycles  <= '0;
            rec_timeout <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        peak_q  <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    peak_q <= peak_d;
                    if (finish || wd_hit) begin
                        state_q     <= ST_HOLD;
                        busy        <= 1'b0;
                        rec_valid   <= 1'b1;
                        rec_res     <= res;
                        rec_st      <= st;
                        rec_heap    <= heap;
                        rec_peak    <= peak_d;
                        rec_cycles  <= cnt_inc;
                        rec_timeout <= !finish;
                    end
                end
                ST_HOLD: begin
                    if (rec_ready) begin
                        state_q   <= ST_IDLE;
                        rec_valid <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_q;

endmodule
